// File: rtl/axis_ascon_tag_gate_pkg.sv
// Shared definitions for the Ascon tag gate: buffer entry layout,
// per-message status codes and the gate FSM state encoding.
package axis_ascon_tag_gate_pkg;

   localparam int data_w = 128;
   localparam int keep_w = 16;

   // One buffered plaintext beat, tlast kept in the MSB.
   typedef struct packed {
      logic              last;
      logic [data_w-1:0] data;
      logic [keep_w-1:0] keep;
   } entry_t;

   // Status word reported once per message.
   typedef enum logic [1:0] {
      code_ok       = 2'b00,
      code_tag_fail = 2'b01,
      code_overflow = 2'b10
   } status_e;

   // Gate sequencing.
   typedef enum logic [2:0] {
      state_fill     = 3'd0,
      state_drain    = 3'd1,
      state_wait_tag = 3'd2,
      state_release  = 3'd3,
      state_status   = 3'd4
   } state_e;

endpackage

// File: rtl/axis_ascon_tag_gate_if.sv
// AXI-Stream plaintext channel (valid/ready/last/data/keep) used for both
// the gate's input from the decryptor and its released output.
interface axis_ascon_tag_gate_if;
   import axis_ascon_tag_gate_pkg::*;

   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [data_w-1:0] tdata;
   logic [keep_w-1:0] tkeep;

   modport master (output tvalid, output tlast, output tdata, output tkeep, input tready);
   modport slave  (input tvalid, input tlast, input tdata, input tkeep, output tready);

endinterface

// File: rtl/axis_ascon_tag_gate_buf.sv
// Plaintext holding buffer: 2**aw entries, one write port, a combinational
// read head, and a synchronous clear used to discard a rejected message.
// almost_full tells the writer that the next accepted beat fills the buffer.
module ascon_gate_buf
   import axis_ascon_tag_gate_pkg::*;
#(
   parameter int aw = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   clr,
   input  logic   wr_en,
   input  entry_t wr_data,
   input  logic   rd_en,
   output entry_t rd_data,
   output logic   full,
   output logic   empty,
   output logic   almost_full
);

   localparam int depth = 1 << aw;

   entry_t        mem_r [depth];
   logic [aw:0]   wr_ptr_r;
   logic [aw:0]   rd_ptr_r;
   logic [aw:0]   level_s;

   // Pointer update; clear and reset both empty the buffer.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (wr_en && !full) begin
            wr_ptr_r <= wr_ptr_r + (aw+1)'(1);
         end
         if (rd_en && !empty) begin
            rd_ptr_r <= rd_ptr_r + (aw+1)'(1);
         end
      end
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      if (wr_en && !full && !clr) begin
         mem_r[wr_ptr_r[aw-1:0]] <= wr_data;
      end
   end

   assign full        = (wr_ptr_r[aw] != rd_ptr_r[aw]) && (wr_ptr_r[aw-1:0] == rd_ptr_r[aw-1:0]);
   assign empty       = (wr_ptr_r == rd_ptr_r);
   assign level_s     = wr_ptr_r - rd_ptr_r;
   assign almost_full = (level_s == (aw+1)'(depth - 1));
   assign rd_data     = mem_r[rd_ptr_r[aw-1:0]];

endmodule

// File: rtl/axis_ascon_tag_gate.sv
// Ascon tag gate: buffers decrypted plaintext until the tag comparison
// result arrives, releases it only when the tag difference is zero, and
// emits one status word per message so unauthenticated data never escapes.
module axis_ascon_tag_gate
   import axis_ascon_tag_gate_pkg::*;
#(
   parameter int buf_aw    = 4,
   parameter bit status_ok = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   axis_ascon_tag_gate_if.slave  s,
   input  logic                  s_tag_tvalid,
   output logic                  s_tag_tready,
   input  logic [data_w-1:0]     s_tag_tdata,
   axis_ascon_tag_gate_if.master m,
   output logic                  m_status_tvalid,
   input  logic                  m_status_tready,
   output logic [1:0]            m_status_tdata
);

   state_e  state_r, state_s;
   logic    ovf_r, ovf_s;
   status_e status_r, status_s;

   logic    s_ready_s, tag_ready_s, m_valid_s, st_valid_s;
   logic    wr_en_s, rd_en_s, clr_s;
   logic    buf_full_s, buf_empty_s, buf_afull_s;
   entry_t  wr_entry_s, head_s;

   assign wr_entry_s = '{last: s.tlast, data: s.tdata, keep: s.tkeep};

   ascon_gate_buf #(.aw(buf_aw)) u_buf (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr_s),
      .wr_en       (wr_en_s),
      .wr_data     (wr_entry_s),
      .rd_en       (rd_en_s),
      .rd_data     (head_s),
      .full        (buf_full_s),
      .empty       (buf_empty_s),
      .almost_full (buf_afull_s)
   );

   // Next-state, buffer control and handshake decode for the gate FSM.
   always_comb begin
      state_s     = state_r;
      ovf_s       = ovf_r;
      status_s    = status_r;
      s_ready_s   = 1'b0;
      tag_ready_s = 1'b0;
      m_valid_s   = 1'b0;
      st_valid_s  = 1'b0;
      wr_en_s     = 1'b0;
      rd_en_s     = 1'b0;
      clr_s       = 1'b0;
      case (state_r)
         state_fill: begin
            s_ready_s = !buf_full_s && !rst;
            if (s.tvalid && s_ready_s) begin
               wr_en_s = 1'b1;
               if (s.tlast) begin
                  state_s = state_wait_tag;
               end else if (buf_afull_s) begin
                  // Buffer is full after this beat but the message goes on:
                  // flag overflow now so upstream never sees a ready gap.
                  ovf_s   = 1'b1;
                  state_s = state_drain;
               end else begin
                  state_s = state_fill;
               end
            end else if (buf_full_s) begin
               ovf_s   = 1'b1;
               state_s = state_drain;
            end else begin
               state_s = state_fill;
            end
         end
         state_drain: begin
            s_ready_s = !rst;
            if (s.tvalid && s_ready_s && s.tlast) begin
               state_s = state_wait_tag;
            end else begin
               state_s = state_drain;
            end
         end
         state_wait_tag: begin
            tag_ready_s = 1'b1;
            if (s_tag_tvalid) begin
               if (ovf_r) begin
                  status_s = code_overflow;
                  clr_s    = 1'b1;
                  state_s  = state_status;
               end else if (s_tag_tdata != '0) begin
                  status_s = code_tag_fail;
                  clr_s    = 1'b1;
                  state_s  = state_status;
               end else begin
                  state_s  = state_release;
               end
            end else begin
               state_s = state_wait_tag;
            end
         end
         state_release: begin
            m_valid_s = !buf_empty_s;
            if (m_valid_s && m.tready) begin
               rd_en_s = 1'b1;
               if (head_s.last) begin
                  if (status_ok) begin
                     status_s = code_ok;
                     state_s  = state_status;
                  end else begin
                     state_s  = state_fill;
                  end
               end else begin
                  state_s = state_release;
               end
            end else begin
               state_s = state_release;
            end
         end
         state_status: begin
            st_valid_s = 1'b1;
            if (m_status_tready) begin
               ovf_s   = 1'b0;
               state_s = state_fill;
            end else begin
               state_s = state_status;
            end
         end
         default: begin
            ovf_s   = 1'b0;
            state_s = state_fill;
         end
      endcase
   end

   // FSM state, overflow flag and status code registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= state_fill;
         ovf_r    <= 1'b0;
         status_r <= code_ok;
      end else begin
         state_r  <= state_s;
         ovf_r    <= ovf_s;
         status_r <= status_s;
      end
   end

   assign s.tready        = s_ready_s;
   assign s_tag_tready    = tag_ready_s;
   assign m.tvalid        = m_valid_s;
   assign m.tlast         = head_s.last;
   assign m.tdata         = head_s.data;
   assign m.tkeep         = head_s.keep;
   assign m_status_tvalid = st_valid_s;
   assign m_status_tdata  = status_r;

endmodule
